// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and per-stage payload widths for the generic pipeline stage register.
// Stages size their DATA_W from these widths and pack/unpack fields themselves.
package pipe_stage_reg_pkg;

  // Held-entry state is {main_valid, skid_valid}; 01 can never be reached.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BAD   = 2'b01,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } stage_state_e;

  localparam int PC_W     = 32;
  localparam int INSN_W   = 32;
  localparam int CTRL_W   = 16;
  localparam int VALUE_W  = 32;
  localparam int IMM_W    = 32;
  localparam int SHAMT_W  = 5;
  localparam int DEST_W   = 5;
  localparam int STATUS_W = 4;
  localparam int SRC_W    = 5;

  localparam int IF_ID_PAYLOAD_W  = PC_W + INSN_W;
  localparam int ID_EX_PAYLOAD_W  = PC_W + CTRL_W + VALUE_W + IMM_W + SHAMT_W
                                  + DEST_W + STATUS_W + 2 * SRC_W;
  localparam int EX_MEM_PAYLOAD_W = PC_W + CTRL_W + 2 * VALUE_W + DEST_W + STATUS_W;
  localparam int MEM_WB_PAYLOAD_W = CTRL_W + VALUE_W + DEST_W + STATUS_W;

  function automatic logic [1:0] occ_count(input stage_state_e s);
    logic [1:0] v;
    v = s;
    return {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: counts edges with inc high, sticks at all-ones.
// Cleared only by the asynchronous reset.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register: valid/ready with a 2-entry skid so in_ready is a flop,
// 1-cycle latency, full throughput, synchronous flush, saturating stall counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W         = 128,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  stage_state_e state;
  logic         accept;
  logic         drain;

  assign state  = stage_state_e'({main_valid_q, skid_valid_q});
  assign accept = in_valid & in_ready;
  assign drain  = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;

    case (state)
      ST_EMPTY: begin
        if (accept) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_data_d = in_data;
        end else if (drain) begin
          main_valid_d = 1'b0;
        end else if (accept) begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
        end
      end
      ST_FULL: begin
        if (drain) begin
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end
      end
      ST_BAD: begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end
      default: ;
    endcase

    // Flush overrides everything; a drain this cycle was still taken downstream.
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      if (CLEAR_ON_FLUSH) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (main_valid_q & ~out_ready),
    .cnt (stall_cnt)
  );

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = (CLEAR_ON_FLUSH && !main_valid_q) ? '0 : main_data_q;
  assign occupancy = occ_count(state);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a FIFO-queue model checked every cycle plus literal pins.
// Two instances share stimulus; the second uses a 4-bit stall counter to exercise saturation.
module tb_pipe_stage_reg;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;

  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  logic          in_ready4, out_valid4;
  logic [DW-1:0] out_data4;
  logic [1:0]    occupancy4;
  logic [3:0]    stall_cnt4;

  pipe_stage_reg #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b1), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .occupancy(occupancy4), .stall_cnt(stall_cnt4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of at most two entries.
  logic [DW-1:0] mq[$];
  int            m_cnt16 = 0;
  int            m_cnt4  = 0;

  always @(posedge clk or posedge rst) begin
    int  n;
    bit  acc, drn;
    if (rst) begin
      mq.delete();
      m_cnt16 = 0;
      m_cnt4  = 0;
    end else begin
      n   = mq.size();
      acc = in_valid && (n < 2);
      drn = (n > 0) && out_ready;
      if ((n > 0) && !out_ready) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15)     m_cnt4++;
      end
      if (flush) mq.delete();
      else begin
        if (drn) void'(mq.pop_front());
        if (acc) mq.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    logic [DW-1:0] exp_d;
    if (chk_en && !rst) begin
      exp_d = (mq.size() > 0) ? mq[0] : '0;
      chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
      chk("out_data", out_data, exp_d);
      chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
      chk("occupancy", {30'd0, occupancy}, mq.size());
      chk("stall_cnt", {16'd0, stall_cnt}, m_cnt16);
      chk("out_data4", out_data4, exp_d);
      chk("in_ready4", {31'd0, in_ready4}, {31'd0, mq.size() < 2});
      chk("stall_cnt4", {28'd0, stall_cnt4}, m_cnt4);
    end
  end

  // Drive one cycle's inputs, wait for the edge, return 1 time unit after it.
  task automatic cyc(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst occupancy", {30'd0, occupancy}, 32'd0);
    chk("rst stall_cnt", {16'd0, stall_cnt}, 32'd0);

    // Streaming: each word appears one edge after it is offered.
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, DW'(i), 1'b1, 1'b0);
      chk("stream data", out_data, i);
      chk("stream in_ready", {31'd0, in_ready}, 32'd1);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("stream idle", {31'd0, out_valid}, 32'd0);

    // Backpressure: A to main, B to skid, C held off.
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    chk("bp A occ", {30'd0, occupancy}, 32'd1);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    chk("bp B in_ready", {31'd0, in_ready}, 32'd0);
    cyc(1'b1, 32'hC, 1'b0, 1'b0);
    chk("bp C occ", {30'd0, occupancy}, 32'd2);
    chk("bp C head", out_data, 32'hA);
    cyc(1'b1, 32'hC, 1'b1, 1'b0);
    chk("bp out B", out_data, 32'hB);
    cyc(1'b1, 32'hC, 1'b1, 1'b0);
    chk("bp out C", out_data, 32'hC);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("bp stall", {16'd0, stall_cnt}, 32'd2);

    // Flush in FULL with D offered; drain in the same cycle keeps the counter still.
    cyc(1'b1, 32'h11, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 1'b0, 1'b0);
    chk("pre-flush occ", {30'd0, occupancy}, 32'd2);
    cyc(1'b1, 32'hD, 1'b1, 1'b1);
    chk("flush out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush occ", {30'd0, occupancy}, 32'd0);
    chk("flush out_data", out_data, 32'd0);
    chk("flush stall", {16'd0, stall_cnt}, 32'd3);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("no D", {31'd0, out_valid}, 32'd0);

    // Saturation: 20 stalled edges.
    cyc(1'b1, 32'h5, 1'b0, 1'b0);
    repeat (20) cyc(1'b0, '0, 1'b0, 1'b0);
    chk("sat cnt4", {28'd0, stall_cnt4}, 32'd15);
    chk("sat cnt16", {16'd0, stall_cnt}, 32'd23);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges while FULL.
    cyc(1'b1, 32'h66, 1'b0, 1'b0);
    cyc(1'b1, 32'h77, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("pre-rst occ", {30'd0, occupancy}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst out_data", out_data, 32'd0);
    chk("arst occ", {30'd0, occupancy}, 32'd0);
    chk("arst stall", {16'd0, stall_cnt}, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 32'h88, 1'b1, 1'b0);
    chk("post-rst data", out_data, 32'h88);
    cyc(1'b0, '0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
